// File: rtl/sdr_rd_pkg.sv
// Shared SDRAM read-path definitions: parameter defaults, command encodings,
// bus widths and the latched request payload.
package sdr_rd_pkg;

  localparam int unsigned DEF_NRCD      = 3;
  localparam int unsigned DEF_CAS_LAT   = 3;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned DEF_NRP       = 3;

  localparam int unsigned BA_W       = 2;
  localparam int unsigned A_W        = 13;
  localparam int unsigned ROW_W      = 13;
  localparam int unsigned COL_W      = 9;
  localparam int unsigned DQ_W       = 16;
  localparam int unsigned DQM_W      = 2;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned WORD_CNT_W = 3;

  // {nRAS, nCAS, nWE}
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;

  typedef struct packed {
    logic [BA_W-1:0]  bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } sdr_addr_t;

  // Column on the address bus with A10 low, so READ never auto-precharges.
  function automatic logic [A_W-1:0] col_to_a(input logic [COL_W-1:0] col);
    return A_W'(col);
  endfunction

endpackage

// File: rtl/sdr_rd.sv
// SDRAM single-burst read controller: ACTIVE, READ, capture one burst after
// CAS latency, PRECHARGE, then a one-cycle done pulse.
module sdr_rd
  import sdr_rd_pkg::*;
#(
  parameter int unsigned NRCD      = DEF_NRCD,
  parameter int unsigned CAS_LAT   = DEF_CAS_LAT,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned NRP       = DEF_NRP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              sdr_CKE,
  output logic              sdr_nCS,
  output logic [BA_W-1:0]   sdr_BA,
  output logic [A_W-1:0]    sdr_A,
  output logic              sdr_nRAS,
  output logic              sdr_nCAS,
  output logic              sdr_nWE,
  input  logic [DQ_W-1:0]   sdr_DQ,
  output logic [DQM_W-1:0]  sdr_DQM,
  input  logic              sdr_rd_req,
  input  logic [BA_W-1:0]   sdr_bank_addr,
  input  logic [ROW_W-1:0]  sdr_row_addr,
  input  logic [COL_W-1:0]  sdr_col_addr,
  output logic [DQ_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic              rd_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_CAS    = 3'd3;
  localparam logic [2:0] S_BURST  = 3'd4;
  localparam logic [2:0] S_PRECH  = 3'd5;

  logic [2:0]            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [WORD_CNT_W-1:0] word, word_nx;
  sdr_addr_t             addr_q, addr_nx;
  logic [2:0]            cmd, cmd_nx;
  logic [BA_W-1:0]       ba_nx;
  logic [A_W-1:0]        a_nx;
  logic [DQ_W-1:0]       data_nx;
  logic                  valid_nx, done_nx;

  assign sdr_CKE = 1'b1;
  assign sdr_nCS = 1'b0;
  assign sdr_DQM = '0;
  assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd;

  // Next-state, phase counter and next registered pin values.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    word_nx  = word;
    addr_nx  = addr_q;
    cmd_nx   = CMD_NOP;
    ba_nx    = sdr_BA;
    a_nx     = sdr_A;
    data_nx  = rd_data;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sdr_rd_req) begin
          state_nx = S_ACTIVE;
          addr_nx  = '{bank: sdr_bank_addr, row: sdr_row_addr, col: sdr_col_addr};
          cmd_nx   = CMD_ACTIVE;
          ba_nx    = sdr_bank_addr;
          a_nx     = sdr_row_addr;
        end
      end
      S_ACTIVE: begin
        ba_nx = addr_q.bank;
        a_nx  = addr_q.row;
        if (cnt == CNT_W'(NRCD - 1)) begin
          state_nx = S_READ;
          cmd_nx   = CMD_READ;
          a_nx     = col_to_a(addr_q.col);
        end
      end
      S_READ: begin
        state_nx = (CAS_LAT > 1) ? S_CAS : S_BURST;
        word_nx  = '0;
      end
      S_CAS: begin
        if (cnt == CNT_W'(CAS_LAT - 2)) state_nx = S_BURST;
      end
      S_BURST: begin
        data_nx  = sdr_DQ;
        valid_nx = 1'b1;
        word_nx  = word + WORD_CNT_W'(1);
        // Precharge lines up with the last captured word.
        if (word == WORD_CNT_W'(BURST_LEN - 1)) begin
          state_nx = S_PRECH;
          cmd_nx   = CMD_PRECHARGE;
          ba_nx    = addr_q.bank;
          a_nx[10] = 1'b0;
        end
      end
      S_PRECH: begin
        if (cnt == CNT_W'(NRP - 1)) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      word     <= '0;
      addr_q   <= '0;
      cmd      <= CMD_NOP;
      sdr_BA   <= '0;
      sdr_A    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      word     <= word_nx;
      addr_q   <= addr_nx;
      cmd      <= cmd_nx;
      sdr_BA   <= ba_nx;
      sdr_A    <= a_nx;
      rd_data  <= data_nx;
      rd_valid <= valid_nx;
      rd_done  <= done_nx;
      rd_busy  <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sdr_rd.sv
// Bench for sdr_rd: default and CL2/BL8/RCD2 instances against a cycle-timeline
// reference and a small SDRAM DQ model.
module tb_sdr_rd;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_PRE = 3'b010;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        valid;
    logic [15:0] data;
    logic        done;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [1:0]       b;
    logic [12:0]      r;
    logic [8:0]       c;
    logic [7:0][15:0] w;
    logic [12:0]      exp_rd_a;
    int               mode;
  } vec_t;

  logic clk, rst_n;
  logic        req [2];
  logic [1:0]  bank [2];
  logic [12:0] row [2];
  logic [8:0]  col [2];
  logic [15:0] dq [2];
  logic        cke [2], ncs [2], nras [2], ncas [2], nwe [2];
  logic [1:0]  ba [2], dqm [2];
  logic [12:0] a [2];
  logic [15:0] data [2];
  logic        valid [2], done [2], busy [2];

  int p_nrcd [2] = '{3, 2};
  int p_cl   [2] = '{3, 2};
  int p_bl   [2] = '{4, 8};
  int p_nrp  [2] = '{3, 3};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  logic [1:0]  last_ba [2];
  logic [12:0] last_a [2];

  logic [15:0] feed0 [$];
  logic [15:0] feed1 [$];
  logic [15:0] sched [int];

  sdr_rd dut0 (
    .clk(clk), .rst_n(rst_n), .sdr_CKE(cke[0]), .sdr_nCS(ncs[0]), .sdr_BA(ba[0]),
    .sdr_A(a[0]), .sdr_nRAS(nras[0]), .sdr_nCAS(ncas[0]), .sdr_nWE(nwe[0]),
    .sdr_DQ(dq[0]), .sdr_DQM(dqm[0]), .sdr_rd_req(req[0]), .sdr_bank_addr(bank[0]),
    .sdr_row_addr(row[0]), .sdr_col_addr(col[0]), .rd_data(data[0]),
    .rd_valid(valid[0]), .rd_done(done[0]), .rd_busy(busy[0])
  );

  sdr_rd #(.NRCD(2), .CAS_LAT(2), .BURST_LEN(8), .NRP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .sdr_CKE(cke[1]), .sdr_nCS(ncs[1]), .sdr_BA(ba[1]),
    .sdr_A(a[1]), .sdr_nRAS(nras[1]), .sdr_nCAS(ncas[1]), .sdr_nWE(nwe[1]),
    .sdr_DQ(dq[1]), .sdr_DQM(dqm[1]), .sdr_rd_req(req[1]), .sdr_bank_addr(bank[1]),
    .sdr_row_addr(row[1]), .sdr_col_addr(col[1]), .rd_data(data[1]),
    .rd_valid(valid[1]), .rd_done(done[1]), .rd_busy(busy[1])
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] feed_pop(input int d);
    if (d == 0) return (feed0.size() > 0) ? feed0.pop_front() : 16'hBAD0;
    return (feed1.size() > 0) ? feed1.pop_front() : 16'hBAD1;
  endfunction

  // SDRAM model: a READ seen in cycle c puts word k on DQ in cycle c+CL+k.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ({nras[d], ncas[d], nwe[d]} == C_RD)
        for (int k = 0; k < p_bl[d]; k++) sched[d * 1000000 + cyc + p_cl[d] + k] = feed_pop(d);
      if (sched.exists(d * 1000000 + cyc)) begin
        dq[d] = sched[d * 1000000 + cyc];
        sched.delete(d * 1000000 + cyc);
      end else begin
        dq[d] = 16'($urandom);
      end
    end
  end

  function automatic obs_t observe(input int d);
    obs_t o;
    o = '{cmd: {nras[d], ncas[d], nwe[d]}, ba: ba[d], a: a[d], valid: valid[d],
          data: data[d], done: done[d], busy: busy[d]};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got cmd=%b ba=%0d a=%h v=%b d=%h done=%b busy=%b | expected cmd=%b ba=%0d a=%h v=%b d=%h done=%b busy=%b",
               name, got.cmd, got.ba, got.a, got.valid, got.data, got.done, got.busy,
               exp.cmd, exp.ba, exp.a, exp.valid, exp.data, exp.done, exp.busy);
    end
  endtask

  task automatic check_static(input int d);
    n_tests++;
    if ({cke[d], ncs[d], dqm[d]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL static_pins dut%0d: got cke/ncs/dqm=%b expected 1000", d, {cke[d], ncs[d], dqm[d]});
    end
  endtask

  task automatic idle_check(input int d, input int n, input string tag);
    obs_t e, g;
    req[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = '{cmd: C_NOP, ba: last_ba[d], a: last_a[d], valid: 1'b0, data: 16'h0, done: 1'b0, busy: 1'b0};
      g = observe(d);
      if (!g.valid) g.data = 16'h0;
      check_obs($sformatf("%s dut%0d idle+%0d", tag, d, i + 1), g, e);
    end
  endtask

  // Called at the negedge of cycle 0; returns at the negedge of the rd_done cycle.
  // mode: 0 = single-cycle request, 1 = extra pulse in cycles 5..9, 2 = held high.
  task automatic run_txn(input int d, input logic [1:0] b, input logic [12:0] r, input logic [8:0] c,
                         input logic [7:0][15:0] w, input logic [12:0] exp_rd_a, input int mode,
                         input string tag);
    int t_rd, t_pre, t_v0, t_end;
    obs_t e, g;
    t_rd  = 1 + p_nrcd[d];
    t_pre = t_rd + p_cl[d] + p_bl[d];
    t_v0  = t_rd + p_cl[d] + 1;
    t_end = t_pre + p_nrp[d];
    for (int k = 0; k < p_bl[d]; k++) begin
      if (d == 0) feed0.push_back(w[k]);
      else        feed1.push_back(w[k]);
    end
    req[d] = 1'b1; bank[d] = b; row[d] = r; col[d] = c;
    for (int o = 1; o <= t_end; o++) begin
      @(negedge clk);
      e.cmd   = (o == 1) ? C_ACT : (o == t_rd) ? C_RD : (o == t_pre) ? C_PRE : C_NOP;
      e.ba    = b;
      e.a     = (o < t_rd) ? r : exp_rd_a;
      e.valid = (o >= t_v0) && (o <= t_pre);
      e.data  = e.valid ? w[o - t_v0] : 16'h0;
      e.done  = (o == t_end);
      e.busy  = (o < t_end);
      g = observe(d);
      if (!g.valid) g.data = 16'h0;
      check_obs($sformatf("%s dut%0d cyc%0d", tag, d, o), g, e);
      req[d]  = (mode == 2) || (mode == 1 && o >= 5 && o <= 9);
      bank[d] = 2'($urandom);
      row[d]  = 13'($urandom);
      col[d]  = 9'($urandom);
    end
    last_ba[d] = b;
    last_a[d]  = exp_rd_a;
  endtask

  vec_t vecs [5];
  obs_t rst_exp, g;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd2, 13'h1ABC, 9'h055, {64'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 13'h0055, 0};
    vecs[1] = '{2'd0, 13'h0000, 9'h000, {64'h0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, 13'h0000, 0};
    vecs[2] = '{2'd3, 13'h1FFF, 9'h1FF, {64'h0, 16'hBEEF, 16'hDEAD, 16'h5A5A, 16'hA5A5}, 13'h01FF, 1};
    vecs[3] = '{2'd1, 13'h0400, 9'h100, {64'h0, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 13'h0100, 2};
    vecs[4] = '{2'd2, 13'h0001, 9'h0AA, {64'h0, 16'hC0DE, 16'h8001, 16'h7FFE, 16'h1234}, 13'h00AA, 0};
    rst_exp = '{cmd: C_NOP, ba: 2'd0, a: 13'h0, valid: 1'b0, data: 16'h0, done: 1'b0, busy: 1'b0};

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; bank[d] = '0; row[d] = '0; col[d] = '0;
      last_ba[d] = '0; last_a[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_obs($sformatf("reset dut%0d", d), observe(d), rst_exp);
      check_static(d);
    end
    rst_n = 1'b1;
    idle_check(0, 20, "post_reset");

    // Directed table: spec example, extremes, ignored pulse, held request.
    foreach (vecs[i])
      run_txn(0, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].w, vecs[i].exp_rd_a, vecs[i].mode,
              $sformatf("vec%0d", i));
    idle_check(0, 3, "after_vecs");

    // Long-CL/BL configuration: READ at 3, data 6..13, PRECHARGE 13, done 16.
    run_txn(1, 2'd1, 13'h0123, 9'h1F0,
            {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
            13'h01F0, 0, "cl2bl8");
    idle_check(1, 3, "cl2bl8");

    // Reset in cycle 9 while a burst is being returned.
    feed0.push_back(16'hAAAA); feed0.push_back(16'hBBBB);
    feed0.push_back(16'hCCCC); feed0.push_back(16'hDDDD);
    req[0] = 1'b1; bank[0] = 2'd3; row[0] = 13'h0ABC; col[0] = 9'h033;
    for (int o = 1; o <= 9; o++) begin
      @(negedge clk);
      req[0] = 1'b0;
    end
    g = observe(0);
    n_tests++;
    if (g.valid !== 1'b1 || g.data !== 16'hBBBB) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got v=%b d=%h expected v=1 d=bbbb", g.valid, g.data);
    end
    #1 rst_n = 1'b0;
    #1 check_obs("async_reset", observe(0), rst_exp);
    sched.delete(); feed0.delete(); feed1.delete();
    last_ba[0] = '0; last_a[0] = '0;
    last_ba[1] = '0; last_a[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 12, "after_mid_reset");

    // Randomised traffic on both configurations.
    for (int d = 0; d < 2; d++) begin
      int prev_mode, n_txn, mode, gap;
      logic [7:0][15:0] w;
      logic [8:0] c;
      prev_mode = 0;
      n_txn = (d == 0) ? 30 : 10;
      for (int t = 0; t < n_txn; t++) begin
        mode = (t == n_txn - 1) ? 0 : int'($urandom_range(0, 2));
        gap  = (prev_mode == 2) ? 0 : int'($urandom_range(0, 3));
        if (gap > 0) idle_check(d, gap, $sformatf("rnd%0d", t));
        for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
        c = 9'($urandom);
        run_txn(d, 2'($urandom), 13'($urandom), c, w, {4'b0000, c}, mode, $sformatf("rnd%0d", t));
        prev_mode = mode;
      end
      idle_check(d, 2, "rnd_end");
      check_static(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
